vector_store_unit: RTL
======================

# vector_store_unit

Parametrised successor to the vector-register write serializer. It accepts one store command through a start/busy/done handshake and snapshots the operands. It then issues one memory write per accepted cycle: one write for a scalar store, or up to `LANES` strided writes for a vector store. Writes honour a `mem_ready` back-pressure input. The block sits between the vector register file / execute stage and the single-port data memory.

## Interface
- `LANES`, 20, vector elements per register.
- `DATA_W`, 10, element width in bits.
- `ADDR_W`, 6, memory address width in bits.
- `LEN_W`, $clog2(LANES+1), width of `vlen` (derived).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only when `busy`=0.
- `op_type`  in  1  0 = scalar store, 1 = vector store.
- `base_address`  in  ADDR_W  address of element 0.
- `stride`  in  ADDR_W  address increment between elements (unsigned).
- `vlen`  in  LEN_W  number of elements to store (vector store only).
- `vector_data`  in  LANES×DATA_W  packed elements; `[i]` is element i.
- `scalar_data`  in  DATA_W  scalar store value.
- `mem_ready`  in  1  memory accepts the presented write this cycle.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `write_en`  out  1  write valid.
- `write_address`  out  ADDR_W  write address.
- `write_data`  out  DATA_W  write data.

## Operation
- States: IDLE, WRITE. `busy` = (state == WRITE).
- **IDLE, `start`=1:**
  - Snapshot `op_type`, `base_address`, `stride`, `scalar_data` and `vector_data`.
  - Compute effective length: scalar → 1; vector → min(`vlen`, `LANES`).
  - Effective length 0 (vector, `vlen`=0): stay in IDLE, pulse `done` next cycle, issue no write.
  - Otherwise go to WRITE with element index i=0.
- **WRITE:**
  - Present `write_en`=1, `write_address` = base + i·stride mod 2^ADDR_W, `write_data` = scalar snapshot (scalar) or `vector_data[i]` snapshot (vector).
  - A write is accepted on an edge where `write_en`=1 and `mem_ready`=1.
  - On acceptance, i increments. If i was the last element, go to IDLE and set `done`=1 for the next cycle.
  - On `mem_ready`=0, hold address, data and `write_en` unchanged.
- **Command handling:**
  - Address arithmetic is ADDR_W-bit: accumulate `address += stride` with wrap-around. No multiplier is required.
  - `start` while `busy`=1 is ignored; no queueing.
  - Input changes after the capture edge have no effect on the running command.
- **Idle outputs:** `write_en`=0; `write_address`/`write_data` hold their last presented values.
- **Reset:**
  - All outputs 0: `busy`, `done`, `write_en`, `write_address`, `write_data`; state IDLE; index 0.
  - Reset mid-command aborts it: no further writes and no `done` pulse.
  - Reset has priority over `start` in the same cycle.

## Timing
- `start` sampled at edge T → first `write_en`=1 in cycle T+1. All outputs are registered.
- With `mem_ready` held at 1, a command of effective length N occupies `busy` in cycles T+1..T+N.
- `done`=1 in cycle T+N+1 only; `busy`=0 and `write_en`=0 in that cycle.
- Each cycle of `mem_ready`=0 in WRITE adds one cycle to the above.
- Back-to-back: `start` asserted in the `done` cycle is accepted. Its first write appears in the following cycle.
- Zero-length vector: `done` in T+1; `busy` and `write_en` stay 0.
- Throughput: one write per cycle when `mem_ready`=1.

## Test plan
Common stimulus: `LANES`=20, `DATA_W`=10, `ADDR_W`=6; `vector_data[i]`=50+i; `scalar_data`=160; `base_address`=34; `mem_ready`=1 unless stated.

- **Scalar store:** start, `op_type`=0.
  - → T+1: `write_en`=1, addr 34, data 160.
  - → T+2: `done`=1, `write_en`=0, `busy`=0.
- **Unit-stride vector:** `op_type`=1, `stride`=1, `vlen`=4.
  - → T+1..T+4: addr 34..37, data 50..53.
  - → `done` in T+5.
  - → `start` in T+5 with scalar 160 → addr 34, data 160 in T+6.
- **Stride with wrap:** base 60, `stride`=3, `vlen`=3.
  - → addr 60, 63, 2; data 50, 51, 52.
  - → `done` in T+4.
- **Back-pressure and snapshot:** `vlen`=3, stride 1; `mem_ready`=0 during T+2.
  - → addr 35 / data 51 held in T+2 and T+3.
  - → addr 36 / data 52 in T+4; `done` in T+5.
  - → `vector_data` changed after T: writes still show 50/51/52.
  - → `start` pulsed while `busy`: ignored.
- **Length bounds:**
  - `vlen`=0 → no `write_en`; `done` in T+1.
  - `vlen`=25 → clamps to 20 writes; last write addr 53, data 69.
- **Reset mid-command:** `vlen`=5, `rst` asserted after 2 accepted writes.
  - → next cycle all outputs 0, `busy`=0.
  - → no `done` ever pulses for the aborted command.
  - → `rst` together with `start` → command not accepted.

Source files
------------

// File: rtl/vector_store_unit_if.sv
// Store-command and memory-write bundle for vector_store_unit.
// The master side issues commands and models the memory; the slave side is the unit.
interface vector_store_unit_if #(
  parameter int LANES  = 20,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = $clog2(LANES + 1)
);
  logic                    start;
  logic                    op_type;
  logic [ADDR_W-1:0]       base_address;
  logic [ADDR_W-1:0]       stride;
  logic [LEN_W-1:0]        vlen;
  logic [LANES*DATA_W-1:0] vector_data;
  logic [DATA_W-1:0]       scalar_data;
  logic                    mem_ready;
  logic                    busy;
  logic                    done;
  logic                    write_en;
  logic [ADDR_W-1:0]       write_address;
  logic [DATA_W-1:0]       write_data;

  modport master (
    output start, op_type, base_address, stride, vlen, vector_data, scalar_data, mem_ready,
    input  busy, done, write_en, write_address, write_data
  );

  modport slave (
    input  start, op_type, base_address, stride, vlen, vector_data, scalar_data, mem_ready,
    output busy, done, write_en, write_address, write_data
  );
endinterface

// File: rtl/vector_store_unit.sv
// Vector store unit: captures one scalar or strided vector store command and
// serialises it into single-element memory writes under mem_ready back-pressure.
module vector_store_unit #(
  parameter int LANES  = 20,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  vector_store_unit_if.slave  bus
);
  localparam int LEN_W = $clog2(LANES + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        idx_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        eff_len;
  logic                    op_q;
  logic [ADDR_W-1:0]       stride_q;
  logic [LANES*DATA_W-1:0] vec_q;
  logic [DATA_W-1:0]       scalar_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic                    wen_q;
  logic                    done_q;
  logic                    take;
  logic                    accept;
  logic                    last;

  // Effective element count: scalar stores are always one write, vector lengths clamp to LANES.
  function automatic logic [LEN_W-1:0] sat_len(input logic op, input logic [LEN_W-1:0] n);
    if (!op) return LEN_W'(1);
    if (n > LEN_W'(LANES)) return LEN_W'(LANES);
    return n;
  endfunction

  // Element select written as a constant-index scan so no dynamic part-select is needed.
  function automatic logic [DATA_W-1:0] elem(input logic [LANES*DATA_W-1:0] v,
                                             input logic [LEN_W-1:0] i);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LEN_W'(k) == i) r = v[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    eff_len = sat_len(bus.op_type, bus.vlen);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          take = 1'b1;
          if (eff_len != '0) state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          accept = 1'b1;
          last   = (idx_q == len_q - LEN_W'(1));
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Element index, registered write port and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      len_q  <= '0;
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (take) begin
        len_q <= eff_len;
        idx_q <= '0;
        if (eff_len == '0) begin
          done_q <= 1'b1;
        end else begin
          wen_q  <= 1'b1;
          addr_q <= bus.base_address;
          data_q <= bus.op_type ? elem(bus.vector_data, LEN_W'(0)) : bus.scalar_data;
        end
      end else if (accept) begin
        if (last) begin
          wen_q  <= 1'b0;
          done_q <= 1'b1;
          idx_q  <= '0;
        end else begin
          idx_q  <= idx_q + LEN_W'(1);
          addr_q <= addr_q + stride_q;
          data_q <= op_q ? elem(vec_q, idx_q + LEN_W'(1)) : scalar_q;
        end
      end
    end
  end

  // Operand snapshot taken on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (take) begin
      op_q     <= bus.op_type;
      stride_q <= bus.stride;
      vec_q    <= bus.vector_data;
      scalar_q <= bus.scalar_data;
    end
  end

  assign bus.busy          = (state_q == WRITE);
  assign bus.done          = done_q;
  assign bus.write_en      = wen_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
endmodule
